// File: rtl/ula_alu8.sv
// 8-bit ALU with 16 operations and a registered 16-bit result.
// One-cycle latency; a new operation may be accepted every cycle.
module ula_alu8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [3:0]  Seletor,
  output logic [15:0] S,
  output logic        out_valid,
  output logic        div_zero
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpMul  = 4'b0010;
  localparam logic [3:0] OpDiv  = 4'b0011;
  localparam logic [3:0] OpShl  = 4'b0100;
  localparam logic [3:0] OpShr  = 4'b0101;
  localparam logic [3:0] OpRol  = 4'b0110;
  localparam logic [3:0] OpRor  = 4'b0111;
  localparam logic [3:0] OpAnd  = 4'b1000;
  localparam logic [3:0] OpOr   = 4'b1001;
  localparam logic [3:0] OpXor  = 4'b1010;
  localparam logic [3:0] OpNor  = 4'b1011;
  localparam logic [3:0] OpNand = 4'b1100;
  localparam logic [3:0] OpXnor = 4'b1101;
  localparam logic [3:0] OpGt   = 4'b1110;
  localparam logic [3:0] OpEq   = 4'b1111;

  logic [15:0] a_ext;
  logic [15:0] b_ext;
  logic [7:0]  quot;
  logic [8:0]  rem;
  logic [15:0] res;
  logic        res_dz;

  assign a_ext = {8'h00, A};
  assign b_ext = {8'h00, B};

  // Restoring divider; quotient is meaningless for B==0 and is overridden below.
  always_comb begin
    rem  = 9'd0;
    quot = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      rem = {rem[7:0], A[i]};
      if (rem >= {1'b0, B}) begin
        rem     = rem - {1'b0, B};
        quot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    res    = 16'h0000;
    res_dz = 1'b0;
    case (Seletor)
      OpAdd:  res = a_ext + b_ext;
      OpSub:  res = a_ext - b_ext;
      OpMul:  res = a_ext * b_ext;
      OpDiv: begin
        if (B == 8'h00) begin
          res    = 16'hFFFF;
          res_dz = 1'b1;
        end else begin
          res = {8'h00, quot};
        end
      end
      OpShl:  res = a_ext << B[2:0];
      OpShr:  res = {8'h00, A >> B[2:0]};
      OpRol:  res = {8'h00, A[6:0], A[7]};
      OpRor:  res = {8'h00, A[0], A[7:1]};
      OpAnd:  res = {8'h00, A & B};
      OpOr:   res = {8'h00, A | B};
      OpXor:  res = {8'h00, A ^ B};
      OpNor:  res = {8'h00, ~(A | B)};
      OpNand: res = {8'h00, ~(A & B)};
      OpXnor: res = {8'h00, ~(A ^ B)};
      OpGt:   res = {15'd0, A > B};
      OpEq:   res = {15'd0, A == B};
      default: res = 16'h0000;
    endcase
  end

  // S and div_zero only change when an operation is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= 16'h0000;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S        <= res;
        div_zero <= res_dz;
      end
    end
  end

endmodule

// File: tb/tb_ula_alu8.sv
// Self-checking bench for ula_alu8: directed cases, async reset, then random ops
// compared against an arithmetic reference model.
module tb_ula_alu8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  Seletor;
  logic [15:0] S;
  logic        out_valid;
  logic        div_zero;

  int n_cmp;
  int n_err;
  logic [15:0] exp_s;
  logic        exp_dz;

  ula_alu8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Seletor   (Seletor),
    .S         (S),
    .out_valid (out_valid),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int op, input int a, input int b);
    int r;
    bit dz;
    dz = 1'b0;
    r  = 0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3:  if (b == 0) begin r = 65535; dz = 1'b1; end else r = a / b;
      4:  r = a << (b % 8);
      5:  r = a >> (b % 8);
      6:  r = (a * 2) % 256 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 255 - (a | b);
      12: r = 255 - (a & b);
      13: r = 255 - (a ^ b);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    return {dz, 16'(r & 32'h0000FFFF)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Presents one cycle of input (valid or idle) and checks the registered outputs.
  task automatic step(input logic v, input int op, input int a, input int b, input string tag);
    logic [16:0] m;
    @(negedge clk);
    in_valid = v;
    Seletor  = 4'(op);
    A        = 8'(a);
    B        = 8'(b);
    @(posedge clk);
    #1;
    if (v) begin
      m      = model(op, a, b);
      exp_s  = m[15:0];
      exp_dz = m[16];
    end
    check({tag, ".S"}, S, exp_s);
    check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
    check({tag, ".dz"}, {15'd0, div_zero}, {15'd0, exp_dz});
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_s    = 16'h0000;
    exp_dz   = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    Seletor  = 4'h0;
    #1;
    check("reset.S", S, 16'h0000);
    check("reset.valid", {15'd0, out_valid}, 16'h0000);
    check("reset.dz", {15'd0, div_zero}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 0, 8'hFE, 8'hF5, "add1");
    check("add1.lit", S, 16'h01F3);
    step(1'b1, 0, 8'h18, 8'h1F, "add2");
    check("add2.lit", S, 16'h0037);
    step(1'b0, 0, 0, 0, "idle1");
    step(1'b1, 1, 8'hC2, 8'hB8, "sub1");
    check("sub1.lit", S, 16'h000A);
    step(1'b1, 1, 8'hFF, 8'hF7, "sub2");
    step(1'b1, 1, 8'h05, 8'h0A, "sub3");
    check("sub3.lit", S, 16'hFFFB);
    step(1'b1, 2, 8'hFE, 8'hF5, "mul1");
    check("mul1.lit", S, 16'hF316);
    step(1'b1, 2, 8'hFF, 8'hFB, "mul2");
    step(1'b1, 2, 8'h44, 8'h4F, "mul3");
    check("mul3.lit", S, 16'h14FC);
    step(1'b1, 3, 8'hEA, 8'h09, "div1");
    check("div1.lit", S, 16'h001A);
    step(1'b1, 3, 8'hFF, 8'h00, "div0");
    check("div0.lit", S, 16'hFFFF);
    check("div0.dzlit", {15'd0, div_zero}, 16'h0001);
    step(1'b0, 0, 0, 0, "idle_dz");
    step(1'b1, 0, 1, 1, "add11");
    check("add11.lit", S, 16'h0002);
    step(1'b1, 6, 8'h81, 0, "rol");
    check("rol.lit", S, 16'h0003);
    step(1'b1, 7, 8'h81, 0, "ror");
    check("ror.lit", S, 16'h00C0);
    step(1'b1, 4, 8'hFF, 3, "shl");
    check("shl.lit", S, 16'h07F8);
    step(1'b1, 12, 8'hCA, 8'h0F, "nand");
    check("nand.lit", S, 16'h00F5);
    step(1'b1, 14, 8'h10, 8'h0F, "gt");
    check("gt.lit", S, 16'h0001);
    step(1'b1, 15, 8'h5A, 8'h5A, "eq");
    check("eq.lit", S, 16'h0001);

    // Asynchronous reset between edges while an op is being presented.
    @(negedge clk);
    in_valid = 1'b1;
    Seletor  = 4'h2;
    A        = 8'hFF;
    B        = 8'hFF;
    #2;
    rst = 1'b1;
    #1;
    check("arst.S", S, 16'h0000);
    check("arst.valid", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    exp_s    = 16'h0000;
    exp_dz   = 1'b0;
    step(1'b0, 0, 0, 0, "post_rst1");
    step(1'b0, 0, 0, 0, "post_rst2");

    for (int i = 0; i < 300; i++) begin
      int op;
      int a;
      int b;
      op = int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      step(($urandom_range(0, 4) != 0), op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
